// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 bus arbiter: FSM state encoding and pointer sizing.
package l2_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index width for N requesters, never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/l2_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the priority pointer.
import l2_arb_pkg::*;

module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_win,
  output logic          o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [31:0]    w_off;
  logic [31:0]    w_idx;
  logic           w_found;

  // Rotate so the pointer position lands at bit 0; the doubled copy supplies the wrap.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];
  assign o_any = |i_req;

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = k;
      end
    end
    w_idx = 32'(i_ptr) + w_off;
    if (w_idx >= N) begin
      w_idx = w_idx - N;
    end
    o_win = PW'(w_idx);
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready L2 front-end port, with invalidate sequencing.
import l2_arb_pkg::*;

module l2_bus_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  input  logic                            inv_req,
  output logic                            s_force_inv,
  output logic                            inv_pending
);

  localparam int unsigned PW = ptr_w(N_MASTERS);
  localparam int unsigned SW = DATA_W / 8;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0] r_ptr,   w_ptr_nxt;
  logic          r_inv_pend;
  logic [PW-1:0] w_win;
  logic          w_any;
  logic [PW-1:0] w_sel;

  rr_pick #(
    .N  (N_MASTERS),
    .PW (PW)
  ) u_pick (
    .i_req (m_valid),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_inv_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_inv_pend <= inv_req | (r_inv_pend & ~s_force_inv);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    s_force_inv = 1'b0;
    s_valid     = 1'b0;
    m_ready     = '0;
    unique case (r_state)
      IDLE: begin
        // A pending invalidate blocks any new grant until it has been issued.
        if (r_inv_pend) begin
          s_force_inv = 1'b1;
        end else if (w_any) begin
          w_grant_nxt = w_win;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_valid          = m_valid[r_grant];
        m_ready[r_grant] = s_ready;
        if (s_ready) begin
          w_ptr_nxt   = (r_grant == PW'(N_MASTERS - 1)) ? '0 : r_grant + 1'b1;
          w_state_nxt = IDLE;
        end else if (!m_valid[r_grant]) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Master 0 drives the slave payload while idle; s_valid is low so it is never sampled.
  assign w_sel       = (r_state == BUSY) ? r_grant : '0;
  assign s_addr      = m_addr[w_sel*ADDR_W +: ADDR_W];
  assign s_wdata     = m_wdata[w_sel*DATA_W +: DATA_W];
  assign s_wstrb     = m_wstrb[w_sel*SW +: SW];
  assign m_rdata     = s_rdata;
  assign inv_pending = r_inv_pend;

endmodule

// File: doc/l2_bus_arbiter.md
Name: l2_bus_arbiter

Overview:
- Round-robin arbiter that shares one native valid/ready L2-cache front-end port among N_MASTERS cache back-ends, for example the instruction and data caches.
- Sequences L2 invalidation: an invalidate request is latched and issued to the L2 only while no transaction is in flight.
- A new grant is never started while an invalidate is pending.
- Sits between the L1 cache back-end buses and the L2 AXI cache front-end.

Parameters:
- N_MASTERS, 2, number of requesters (2..8).
- ADDR_W, 24, byte-address width of each master and the slave.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- m_valid  in  N_MASTERS  per-master request valid
- m_addr  in  N_MASTERS*ADDR_W  addresses; master i occupies slice [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  write data, sliced the same way
- m_wstrb  in  N_MASTERS*DATA_W/8  write strobes (all zero means read)
- m_rdata  out  DATA_W  read data, broadcast to all masters
- m_ready  out  N_MASTERS  per-master one-cycle completion
- s_valid  out  1  to L2 valid
- s_addr  out  ADDR_W  to L2 address
- s_wdata  out  DATA_W  to L2 write data
- s_wstrb  out  DATA_W/8  to L2 write strobes
- s_rdata  in  DATA_W  from L2 read data
- s_ready  in  1  from L2 completion
- inv_req  in  1  single-cycle invalidate request (L1 force_inv_out)
- s_force_inv  out  1  single-cycle invalidate pulse to L2
- inv_pending  out  1  an invalidate is latched and not yet issued

Behaviour:
- Reset (asynchronous, any state): state=IDLE, grant=0, prio_ptr=0, inv_pend=0.
  - Outputs while reset is asserted: s_valid=0, m_ready=0, s_force_inv=0, inv_pending=0.
  - Reset mid-transaction abandons it; no m_ready is produced.
- inv_pend register: set on any cycle with inv_req=1. Cleared in the cycle s_force_inv=1, unless inv_req=1 in that same cycle, in which case it stays set. inv_pending = inv_pend.
- State IDLE:
  - Priority 1: if inv_pend=1, drive s_force_inv=1 for this cycle, issue no grant, and stay in IDLE.
  - Priority 2: otherwise, if any m_valid is set, choose the first requester at or after prio_ptr, wrapping modulo N_MASTERS. Register it into grant and go to BUSY.
  - s_valid=0 in IDLE.
- State BUSY:
  - Slave-side signals come combinationally from the granted master: s_valid=m_valid[grant]; s_addr, s_wdata and s_wstrb are its slices.
  - m_ready[grant]=s_ready; every other m_ready bit is 0. m_rdata=s_rdata at all times.
  - On s_ready=1: set prio_ptr=(grant+1) mod N_MASTERS and go to IDLE.
  - If m_valid[grant] drops without s_ready (protocol violation): go to IDLE with prio_ptr unchanged.
- Latency:
  - A request seen in IDLE appears on s_valid in the next cycle.
  - After each completion there is at least one IDLE cycle before the next grant.
- When idle, s_addr, s_wdata and s_wstrb are driven by master 0 and s_valid=0. The L2 must not sample them.
- inv_req arriving during BUSY: latched, then issued in the first IDLE cycle, ahead of any pending grant.
- Fairness: a continuously requesting master is granted within N_MASTERS grants, plus at most one invalidate cycle before each grant.
- Simultaneous events:
  - inv_req together with s_ready: the completion finishes normally and the invalidate is issued in the next IDLE cycle.
  - All m_valid asserted: pure round-robin order.
  - s_ready while in IDLE: ignored.

Decomposition:
- Package l2_arb_pkg holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1;
  - a function computing the pointer width, clog2(N_MASTERS) with a minimum of 1.
- Sub-module rr_pick (combinational):
  - inputs: request vector, prio_ptr;
  - outputs: winner index, any_req;
  - implementation: rotate, find-first, un-rotate.

Test Plan:
1. Reset release, N_MASTERS=2:
   - Hold m_valid=0 -> s_valid=0, m_ready=00, s_force_inv=0 for 10 cycles.
2. Single read:
   - Stimulus: m_valid=01, m_addr[0]=0x000100, wstrb=0; L2 returns s_ready at cycle +3 with s_rdata=0xDEADBEEF.
   - Required: s_valid rises 1 cycle after the request; s_addr=0x000100; m_ready=01 for exactly 1 cycle; m_rdata=0xDEADBEEF.
3. Contention:
   - Stimulus: m_valid=11 held continuously; L2 responds with 1-cycle latency.
   - Required grant sequence 0,1,0,1; each m_ready pulse is separated by at least 1 IDLE cycle.
4. Invalidate during BUSY:
   - Stimulus: master 1 write (wdata=0x12345678, wstrb=0xF) in flight; pulse inv_req; master 0 requesting.
   - Required: inv_pending=1 until the write completes; s_force_inv=1 in the first IDLE cycle; master 0 is granted only on the cycle after that.
5. Back-to-back invalidates:
   - Stimulus: inv_req on the same cycle as s_force_inv.
   - Required: inv_pending stays 1 and a second s_force_inv pulse follows in the next IDLE cycle.
6. Asynchronous reset during BUSY:
   - Stimulus: assert rst while s_valid=1.
   - Required: s_valid=0 immediately, no m_ready; after release, the first grant uses prio_ptr=0.
